// File: rtl/multiplier_scorer_pkg.sv
// rtl/multiplier_scorer_pkg.sv - shared types and constants for the multiplier scorer
package multiplier_scorer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWEEP  = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    localparam int LAT_MIN = 0;
    localparam int LAT_MAX = 3;

    // Number of operand pairs in an exhaustive sweep of two n-bit operands.
    function automatic int vec_count(input int n);
        return 1 << (2 * n);
    endfunction

endpackage

// File: rtl/scorer_delay_line.sv
// rtl/scorer_delay_line.sv - LAT-stage shift register carrying {valid, expected product}
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clr                 synchronous clear of the valid bits (new sweep)
//   in_valid, in_data   entry into stage 0
//   out_valid, out_data value leaving the last stage (a wire when LAT is 0)
module scorer_delay_line #(
    parameter int W   = 4,
    parameter int LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (LAT == 0) begin : g_wire
            logic unused_ok;
            assign unused_ok = &{1'b0, clk, rst, clr};
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_pipe
            logic [LAT-1:0] vld;
            logic [W-1:0]   dat [LAT];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld <= '0;
                    for (int i = 0; i < LAT; i++) dat[i] <= '0;
                end else begin
                    if (clr) begin
                        vld <= '0;
                    end else begin
                        vld[0] <= in_valid;
                        for (int i = 1; i < LAT; i++) vld[i] <= vld[i-1];
                    end
                    dat[0] <= in_data;
                    for (int i = 1; i < LAT; i++) dat[i] <= dat[i-1];
                end
            end

            assign out_valid = vld[LAT-1];
            assign out_data  = dat[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/multiplier_scorer.sv
// rtl/multiplier_scorer.sv - exhaustive functional scorer for a candidate N x N multiplier
//
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   start       begin a sweep (only honoured in IDLE)
//   a_o, b_o    registered operands driven into the candidate
//   p_i         candidate product, valid LAT cycles after a_o/b_o
//   busy        high while vectors are issued or retiring
//   done        one-cycle pulse when results are final
//   err_count   number of mismatching vectors in the last sweep
//   bit_err     sticky OR of all product-bit differences
//   pass        no mismatches in the last completed sweep
module multiplier_scorer
    import multiplier_scorer_pkg::*;
#(
    parameter int N   = 2,
    parameter int LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [N-1:0]   a_o,
    output logic [N-1:0]   b_o,
    input  logic [2*N-1:0] p_i,
    output logic           busy,
    output logic           done,
    output logic [2*N:0]   err_count,
    output logic [2*N-1:0] bit_err,
    output logic           pass
);

    localparam int            PW         = 2 * N;
    localparam logic [PW-1:0] IDX_MAX    = PW'(vec_count(N) - 1);
    localparam logic [1:0]    DRAIN_LAST = (LAT > 0) ? 2'(LAT - 1) : 2'd0;

    generate
        if (LAT < LAT_MIN || LAT > LAT_MAX) begin : g_bad_lat
            $error("multiplier_scorer: LAT must be within 0..3");
        end
    endgenerate

    state_t        state, state_nx;
    logic [PW-1:0] idx;
    logic [1:0]    drain_cnt;
    logic [PW-1:0] exp_p, dl_exp;
    logic          dl_valid, accept, idx_last, drain_last, mismatch;
    logic [PW:0]   err_nx;
    logic [PW-1:0] bit_nx;

    // Operands come straight from the index register, so they are registered
    // and naturally hold the last vector while draining.
    assign a_o = idx[PW-1:N];
    assign b_o = idx[N-1:0];

    assign accept     = (state == IDLE) && start;
    assign idx_last   = (idx == IDX_MAX);
    assign drain_last = (drain_cnt == DRAIN_LAST);
    assign exp_p      = PW'(a_o) * PW'(b_o);

    scorer_delay_line #(
        .W   (PW),
        .LAT (LAT)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (accept),
        .in_valid  (state == SWEEP),
        .in_data   (exp_p),
        .out_valid (dl_valid),
        .out_data  (dl_exp)
    );

    assign mismatch = dl_valid && (p_i != dl_exp);
    assign err_nx   = err_count + {{PW{1'b0}}, mismatch};
    assign bit_nx   = dl_valid ? (bit_err | (p_i ^ dl_exp)) : bit_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = SWEEP;
            SWEEP: begin
                busy = 1'b1;
                if (idx_last) state_nx = (LAT > 0) ? DRAIN : REPORT;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_last) state_nx = REPORT;
            end
            REPORT: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            drain_cnt <= '0;
            err_count <= '0;
            bit_err   <= '0;
            pass      <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            drain_cnt <= '0;
            err_count <= '0;
            bit_err   <= '0;
            pass      <= 1'b0;
        end else begin
            if (state == SWEEP && !idx_last) idx <= idx + PW'(1);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            err_count <= err_nx;
            bit_err   <= bit_nx;
            // Latch pass on entry to REPORT so it already includes the final
            // compare and is valid in the done cycle.
            if (state_nx == REPORT && state != REPORT) pass <= (err_nx == '0);
        end
    end

endmodule

// File: tb/tb_multiplier_scorer.sv
// tb/tb_multiplier_scorer.sv - self-checking bench for multiplier_scorer
module tb_multiplier_scorer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] a0, b0, a1, b1;
    logic [3:0] p0, p1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [4:0] err0, err1;
    logic [3:0] bit0, bit1;

    // Candidate behaviour: a 16-entry lookup table indexed by {a, b}.
    logic [3:0] tbl [16];
    logic       regd0 = 1'b0;
    logic [3:0] preg0 = 4'd0, preg1 = 4'd0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        preg0 <= tbl[{a0, b0}];
        preg1 <= tbl[{a1, b1}];
    end

    assign p0 = regd0 ? preg0 : tbl[{a0, b0}];
    assign p1 = preg1;

    multiplier_scorer #(.N(2), .LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .start(start), .a_o(a0), .b_o(b0), .p_i(p0),
        .busy(busy0), .done(done0), .err_count(err0), .bit_err(bit0), .pass(pass0)
    );

    multiplier_scorer #(.N(2), .LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .a_o(a1), .b_o(b1), .p_i(p1),
        .busy(busy1), .done(done1), .err_count(err1), .bit_err(bit1), .pass(pass1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: score the table directly over all 16 operand pairs.
    task automatic ref_score(output int e, output logic [3:0] bits);
        logic [3:0] prod;
        e = 0;
        bits = 4'd0;
        for (int i = 0; i < 16; i++) begin
            prod = 4'((i / 4) * (i % 4));
            if (tbl[i] != prod) e++;
            bits |= tbl[i] ^ prod;
        end
    endtask

    task automatic load_ideal(input logic [3:0] xmask);
        for (int i = 0; i < 16; i++) tbl[i] = 4'((i / 4) * (i % 4)) ^ xmask;
    endtask

    int   cyc0, cyc1, nd0, nd1;
    logic busy_at_done0, busy_first0;

    // Start is sampled at the first edge; loop index c names the cycle k+c.
    task automatic sweep(input bit extra_starts);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc0 = -1; cyc1 = -1; nd0 = 0; nd1 = 0;
        busy_first0 = busy0;
        busy_at_done0 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            if (done0) begin
                nd0++;
                if (cyc0 < 0) begin cyc0 = c; busy_at_done0 = busy0; end
            end
            if (done1) begin
                nd1++;
                if (cyc1 < 0) cyc1 = c;
            end
            start = extra_starts && (c == 3 || (done0 && c == cyc0));
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_sweep(input string tag);
        int         e;
        logic [3:0] bits;
        ref_score(e, bits);
        expect_eq({tag, "/busy_k1"},   32'(busy_first0),   1);
        expect_eq({tag, "/done0_cyc"}, cyc0,             17);
        expect_eq({tag, "/done1_cyc"}, cyc1,             18);
        expect_eq({tag, "/done0_n"},   nd0,              1);
        expect_eq({tag, "/done1_n"},   nd1,              1);
        expect_eq({tag, "/busy_done"}, 32'(busy_at_done0), 0);
        expect_eq({tag, "/busy_end"},  32'(busy0 | busy1), 0);
        expect_eq({tag, "/err0"},      32'(err0),        e);
        expect_eq({tag, "/bit0"},      32'(bit0),        32'(bits));
        expect_eq({tag, "/pass0"},     32'(pass0),       32'(e == 0));
        expect_eq({tag, "/err1"},      32'(err1),        e);
        expect_eq({tag, "/bit1"},      32'(bit1),        32'(bits));
        expect_eq({tag, "/pass1"},     32'(pass1),       32'(e == 0));
    endtask

    int nd_rst;

    initial begin
        load_ideal(4'd0);
        repeat (3) @(negedge clk);
        expect_eq("rst/a0",   32'(a0),   0);
        expect_eq("rst/b0",   32'(b0),   0);
        expect_eq("rst/busy", 32'(busy0 | busy1), 0);
        expect_eq("rst/done", 32'(done0 | done1), 0);
        expect_eq("rst/err",  32'(err0 | err1), 0);
        expect_eq("rst/bit",  32'(bit0 | bit1), 0);
        expect_eq("rst/pass", 32'(pass0 | pass1), 0);
        rst = 1'b0;
        @(negedge clk);

        load_ideal(4'd0);
        sweep(1'b0);
        check_sweep("ideal");

        for (int i = 0; i < 16; i++) tbl[i] = 4'd0;
        sweep(1'b0);
        check_sweep("stuck0");
        expect_eq("stuck0/err_const", 32'(err0), 9);
        expect_eq("stuck0/bit_const", 32'(bit0), 32'hf);

        load_ideal(4'b0001);
        sweep(1'b1);
        check_sweep("xor1_pulses");
        expect_eq("xor1/err_const", 32'(err0), 16);
        expect_eq("xor1/bit_const", 32'(bit0), 32'h1);

        // Registered candidate on the LAT=0 scorer is misaligned by one cycle.
        load_ideal(4'd0);
        regd0 = 1'b1;
        sweep(1'b0);
        expect_eq("regd_lat0/err_nz", 32'(err0 > 0), 1);
        expect_eq("regd_lat0/pass",   32'(pass0),    0);
        expect_eq("regd_lat1/err",    32'(err1),     0);
        expect_eq("regd_lat1/pass",   32'(pass1),    1);
        regd0 = 1'b0;

        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 16; i++)
                tbl[i] = ($urandom_range(3) == 0) ? 4'($urandom) : 4'((i / 4) * (i % 4));
            sweep(1'b0);
            check_sweep($sformatf("rand%0d", r));
        end

        // Reset in cycle k+5 of a sweep with a faulty candidate.
        load_ideal(4'b0001);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        expect_eq("midrst/err_before", 32'(err0), 4);
        rst = 1'b1;
        @(negedge clk);
        expect_eq("midrst/ab",   32'({a0, b0, a1, b1}), 0);
        expect_eq("midrst/busy", 32'(busy0 | busy1), 0);
        expect_eq("midrst/err",  32'({err0, err1}), 0);
        expect_eq("midrst/bit",  32'({bit0, bit1}), 0);
        expect_eq("midrst/pass", 32'(pass0 | pass1), 0);
        rst = 1'b0;
        nd_rst = 0;
        for (int c = 0; c < 25; c++) begin
            if (done0 || done1 || busy0 || busy1) nd_rst++;
            @(negedge clk);
        end
        expect_eq("midrst/no_activity", nd_rst, 0);

        load_ideal(4'd0);
        sweep(1'b0);
        check_sweep("after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
